// File: rtl/paged_mem.sv
// Paged single-port memory behind an auto-incrementing address pointer.
// Writes (and optionally reads) wrap inside a 2^PAGE_W-word page.
module paged_mem #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PAGE_W  = 3,
  parameter int unsigned RD_WRAP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l_en,
  input  logic              w_en,
  input  logic              r_en,
  input  logic              wp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic [ADDR_W-1:0] ptr,
  output logic              page_wrap,
  output logic              wp_err
);

  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam bit          RD_WRAP_EN = (RD_WRAP != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] r_data_q;
  logic              r_valid_q, r_valid_d;
  logic              page_wrap_q, page_wrap_d;
  logic              wp_err_q, wp_err_d;

  logic              wr_cmd, rd_cmd, mem_we, page_end;
  logic [ADDR_W-1:0] ptr_inc, ptr_base;

  // Command decode: load beats write beats read.
  always_comb begin
    wr_cmd   = ~l_en & w_en;
    rd_cmd   = ~l_en & ~w_en & r_en;
    mem_we   = wr_cmd & ~wp & ~reset;
    page_end = &ptr_q[PAGE_W-1:0];
    ptr_inc  = ptr_q + ADDR_W'(1);
    ptr_base = {ptr_q[ADDR_W-1:PAGE_W], {PAGE_W{1'b0}}};
  end

  // Next pointer and status pulses.
  always_comb begin
    ptr_d       = ptr_q;
    r_valid_d   = 1'b0;
    page_wrap_d = 1'b0;
    wp_err_d    = 1'b0;
    if (l_en) begin
      ptr_d = addr;
    end else if (w_en) begin
      wp_err_d = wp;
      if (page_end) begin
        ptr_d       = ptr_base;
        page_wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_inc;
      end
    end else if (r_en) begin
      r_valid_d = 1'b1;
      if (RD_WRAP_EN && page_end) begin
        ptr_d       = ptr_base;
        page_wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_inc;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      r_data_q    <= '0;
      r_valid_q   <= 1'b0;
      page_wrap_q <= 1'b0;
      wp_err_q    <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      r_valid_q   <= r_valid_d;
      page_wrap_q <= page_wrap_d;
      wp_err_q    <= wp_err_d;
      if (rd_cmd) begin
        r_data_q <= mem[ptr_q];
      end
    end
  end

  // Array carries no reset so it maps onto block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= w_data;
    end
  end

  assign ptr       = ptr_q;
  assign r_data    = r_data_q;
  assign r_valid   = r_valid_q;
  assign page_wrap = page_wrap_q;
  assign wp_err    = wp_err_q;

endmodule

// File: tb/tb_paged_mem.sv
// Directed bench for paged_mem: one instance with linear reads, one with
// page-wrapping reads, both fed the same command stream.
module tb_paged_mem;

  logic       clk, reset;
  logic       l_en, w_en, r_en, wp;
  logic [7:0] addr, w_data;

  logic [7:0] rd0, ptr0, rd1, ptr1;
  logic       rv0, pw0, we0, rv1, pw1, we1;

  int checks = 0;
  int errors = 0;

  paged_mem #(.DATA_W(8), .ADDR_W(8), .PAGE_W(3), .RD_WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .l_en(l_en), .w_en(w_en), .r_en(r_en), .wp(wp),
    .addr(addr), .w_data(w_data), .r_data(rd0), .r_valid(rv0), .ptr(ptr0),
    .page_wrap(pw0), .wp_err(we0)
  );

  paged_mem #(.DATA_W(8), .ADDR_W(8), .PAGE_W(3), .RD_WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .l_en(l_en), .w_en(w_en), .r_en(r_en), .wp(wp),
    .addr(addr), .w_data(w_data), .r_data(rd1), .r_valid(rv1), .ptr(ptr1),
    .page_wrap(pw1), .wp_err(we1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       l, w, r, p;
    logic [7:0] a, d;
    logic [7:0] eptr;
    logic       erv;
    logic [7:0] erd;
    logic       epw, ewe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic l, input logic w, input logic r, input logic p,
                              input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] eptr, input logic erv, input logic [7:0] erd,
                              input logic epw, input logic ewe);
    vec_t v;
    v.l = l; v.w = w; v.r = r; v.p = p; v.a = a; v.d = d;
    v.eptr = eptr; v.erv = erv; v.erd = erd; v.epw = epw; v.ewe = ewe;
    return v;
  endfunction

  task automatic chk8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic w, input logic r, input logic p,
                       input logic [7:0] a, input logic [7:0] d);
    l_en = l; w_en = w; r_en = r; wp = p; addr = a; w_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int idx);
    chk8("rst_ptr0", idx, ptr0, 8'h00);
    chk8("rst_rd0", idx, rd0, 8'h00);
    chk1("rst_rv0", idx, rv0, 1'b0);
    chk1("rst_pw0", idx, pw0, 1'b0);
    chk1("rst_we0", idx, we0, 1'b0);
    chk8("rst_ptr1", idx, ptr1, 8'h00);
    chk8("rst_rd1", idx, rd1, 8'h00);
    chk1("rst_rv1", idx, rv1, 1'b0);
    chk1("rst_pw1", idx, pw1, 1'b0);
    chk1("rst_we1", idx, we1, 1'b0);
  endtask

  initial begin
    //                l     w     r     wp    addr   data   ptr    rv    r_data pw    wp_err
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA0, 8'h06, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA1, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA3, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 8'h06, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hB6, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hB7, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 8'h00, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hB8, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 8'h06, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h07, 1'b1, 8'hB6, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h08, 1'b1, 8'hB7, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h09, 1'b1, 8'hB8, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h09, 1'b0, 8'hB8, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h05, 1'b0, 8'hB8, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h06, 1'b1, 8'hA0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'hA0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1, 8'hA3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, 8'hA3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC0, 8'hF8, 1'b0, 8'hA3, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, 8'hA3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 8'hC0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0, 8'hC0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h11, 1'b0, 8'hC0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h77, 8'h12, 1'b0, 8'hC0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0, 8'hC0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55, 8'h11, 1'b0, 8'hC0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 8'hC0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h10, 1'b0, 8'hC0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 1'b1, 8'h3C, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h99, 8'h20, 1'b0, 8'h3C, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00, 8'h11, 1'b0, 8'h3C, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h12, 1'b1, 8'h77, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h20, 1'b0, 8'h77, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h21, 1'b0, 8'h77, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h20, 1'b0, 8'h77, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h21, 1'b1, 8'h5A, 1'b0, 1'b0));

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk_zero(0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].l, tbl[i].w, tbl[i].r, tbl[i].p, tbl[i].a, tbl[i].d);
      chk8("ptr", i, ptr0, tbl[i].eptr);
      chk1("r_valid", i, rv0, tbl[i].erv);
      chk8("r_data", i, rd0, tbl[i].erd);
      chk1("page_wrap", i, pw0, tbl[i].epw);
      chk1("wp_err", i, we0, tbl[i].ewe);
    end

    // Page-wrapping reads on dut1 against linear reads on dut0.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hD0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hD1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hD2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0E, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("wrap_ptr1", 1, ptr1, 8'h0F); chk8("wrap_rd1", 1, rd1, 8'hD0);
    chk1("wrap_rv1", 1, rv1, 1'b1);    chk1("wrap_pw1", 1, pw1, 1'b0);
    chk8("lin_ptr0", 1, ptr0, 8'h0F);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("wrap_ptr1", 2, ptr1, 8'h08); chk8("wrap_rd1", 2, rd1, 8'hD1);
    chk1("wrap_rv1", 2, rv1, 1'b1);    chk1("wrap_pw1", 2, pw1, 1'b1);
    chk8("lin_ptr0", 2, ptr0, 8'h10);  chk1("lin_pw0", 2, pw0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("wrap_ptr1", 3, ptr1, 8'h09); chk8("wrap_rd1", 3, rd1, 8'hD2);
    chk1("wrap_rv1", 3, rv1, 1'b1);    chk1("wrap_pw1", 3, pw1, 1'b0);
    chk8("lin_ptr0", 3, ptr0, 8'h11);  chk8("lin_rd0", 3, rd0, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk1("wrap_rv1", 4, rv1, 1'b0);    chk1("wrap_pw1", 4, pw1, 1'b0);
    chk8("wrap_rd1", 4, rd1, 8'hD2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("wrap_ptr1", 5, ptr1, 8'hF8); chk1("wrap_pw1", 5, pw1, 1'b1);
    chk8("wrap_rd1", 5, rd1, 8'hC0);
    chk8("lin_ptr0", 5, ptr0, 8'h00);  chk1("lin_pw0", 5, pw0, 1'b0);

    // Reset in the middle of a write burst.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h32, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h22);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h32, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("pre_rd0", 0, rd0, 8'h11);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hE0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hE1);
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hE2);
    reset = 1'b0;
    chk_zero(1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hF0);
    chk8("post_ptr0", 0, ptr0, 8'h01);
    chk8("post_ptr1", 0, ptr1, 8'h01);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("burst_rd0", 0, rd0, 8'hE0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("burst_rd0", 1, rd0, 8'hE1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("burst_rd0", 2, rd0, 8'h11);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("burst_rd0", 3, rd0, 8'h22);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk8("post_rd0", 0, rd0, 8'hF0);
    chk1("post_rv0", 0, rv0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paged_mem.md
PAGED_MEM -- requirements
Module: paged_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width; depth = 2^ADDR_W words.
REQ-003 The block SHALL have parameter PAGE_W, default 3, meaning page size = 2^PAGE_W words; legal range 1..ADDR_W-1.
REQ-004 The block SHALL have parameter RD_WRAP, default 0, meaning 0 = linear read increment, 1 = read wraps within page like write.
REQ-005 clk  input  1  rising-edge clock; sole clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 l_en  input  1  load internal address pointer from addr.
REQ-008 w_en  input  1  write w_data at pointer, then advance pointer.
REQ-009 r_en  input  1  read word at pointer, then advance pointer.
REQ-010 wp  input  1  write-protect; sampled every cycle w_en is high.
REQ-011 addr  input  ADDR_W  load address.
REQ-012 w_data  input  DATA_W  write data.
REQ-013 r_data  output  DATA_W  registered read data.
REQ-014 r_valid  output  1  one-cycle pulse, r_data valid.
REQ-015 ptr  output  ADDR_W  current address pointer.
REQ-016 page_wrap  output  1  one-cycle pulse, pointer wrapped to page base.
REQ-017 wp_err  output  1  one-cycle pulse, write blocked by wp.

Function
REQ-018 Command priority per cycle SHALL be l_en > w_en > r_en; only the highest-priority asserted command executes.
REQ-019 l_en SHALL set ptr <= addr at the next edge; no memory access that cycle.
REQ-020 w_en with wp=0 SHALL write mem[ptr] <= w_data at the edge.
REQ-021 w_en with wp=1 SHALL leave memory unchanged, pulse wp_err next cycle, and still advance ptr.
REQ-022 On w_en, if ptr[PAGE_W-1:0] is all ones, ptr SHALL become {ptr[ADDR_W-1:PAGE_W], 0} and page_wrap SHALL pulse next cycle; otherwise ptr <= ptr+1.
REQ-023 On r_en with RD_WRAP=0, ptr SHALL become ptr+1 modulo 2^ADDR_W (top address wraps to 0) with no page_wrap pulse.
REQ-024 On r_en with RD_WRAP=1, ptr SHALL follow the REQ-022 wrap rule, including the page_wrap pulse.
REQ-025 On r_en, r_data SHALL be loaded with mem[ptr] (pre-increment pointer) and r_valid SHALL be high the following cycle; read latency = 1.
REQ-026 r_data SHALL hold its last value when r_valid is low.
REQ-027 Back-to-back r_en SHALL yield consecutive words with r_valid high continuously.
REQ-028 Back-to-back w_en SHALL write consecutive addresses with no stall cycle.
REQ-029 page_wrap, wp_err and r_valid SHALL each be a one-cycle registered pulse, low in any cycle not caused by the prior-cycle command.
REQ-030 Simultaneous w_en and r_en without l_en SHALL perform the write only; r_valid SHALL stay low.
REQ-031 Memory SHALL be a single-port synchronous array, inferable as block RAM (no reset on the array).
REQ-032 With no command asserted, ptr and memory SHALL hold.

Reset
REQ-033 reset high at a rising edge SHALL set ptr=0, r_data=0, r_valid=0, page_wrap=0, wp_err=0.
REQ-034 reset SHALL override all commands in the same cycle; no write occurs and memory contents SHALL be preserved.
REQ-035 reset mid-burst SHALL abort the burst; the first command after reset release SHALL act on ptr=0.

Verification
REQ-036 Defaults: l_en addr=0x05, then w_en x4 with data 0xA0..0xA3 -> mem[0x05,0x06,0x07,0x00]=A0..A3, page_wrap pulse after third write, ptr ends 0x01.
REQ-037 RD_WRAP=0: l_en 0x06, r_en x3 -> r_data 0x06,0x07,0x08 contents one cycle after each r_en, no page_wrap; l_en 0xFF, r_en -> ptr=0x00.
REQ-038 RD_WRAP=1: l_en 0x0E, r_en x3 -> reads mem[0x0E],mem[0x0F],mem[0x08], page_wrap pulse once, ptr ends 0x09.
REQ-039 wp=1: l_en 0x10, w_en with 0x55 -> mem[0x10] unchanged, wp_err pulse 1 cycle, ptr=0x11.
REQ-040 Priority: l_en+w_en+r_en together with addr=0x20 -> ptr=0x20, no write, r_valid low; w_en+r_en -> write only.
REQ-041 reset asserted during a 4-write burst after 2 writes -> outputs zeroed, first 2 words retained, remaining 2 not written, next w_en targets 0x00.
